// File: rtl/row_buffer_ctrl.sv
// -----------------------------------------------------------------------------
// row_buffer_ctrl
//
// Per-bank open-row controller placed directly in front of the memory core
// array. A request to a row that is not open starts an activate pulse. After
// T_RCD idle cycles the row is captured into a local row buffer. Column reads
// and writes are then served from that buffer. A miss or a flush writes the
// buffer back to the core with a precharge pulse.
//
// Configuration macro:
//   ROWBUF_AUTO_PRECHARGE_EN  defined   -> closed-page policy: every accepted
//                                          request is followed by PRE
//                             undefined -> open-page policy
//
// Ports (ROW_W = MEM_ELEM_DEPTH * 2**COL_ADDR_DEPTH):
//   clk            in   clock, rising edge
//   reset          in   synchronous, active-high
//   req_valid      in   request present
//   req_ready      out  request accepted this cycle when valid & ready
//   req_we         in   1 = write, 0 = read
//   req_row        in   target row
//   req_col        in   target column
//   req_wdata      in   write data
//   flush          in   close the open row (write back) while in OPEN
//   rd_valid       out  read data valid, 1-cycle pulse
//   rd_data        out  read data
//   row_open       out  a row is held in the buffer
//   mem_activate   out  1-cycle pulse to core: load row
//   mem_precharge  out  1-cycle pulse to core: store row
//   mem_row_addr   out  row address to core, stable around the pulses
//   mem_row_in     out  row buffer contents to core (write-back)
//   mem_row_out    in   row data from core
// -----------------------------------------------------------------------------
module row_buffer_ctrl #(
    parameter int ROW_ADDR_DEPTH = 8,
    parameter int COL_ADDR_DEPTH = 6,
    parameter int MEM_ELEM_DEPTH = 32,
    parameter int T_RCD          = 2,
    parameter int T_RP           = 2,
    localparam int ROW_W         = MEM_ELEM_DEPTH * (2 ** COL_ADDR_DEPTH)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_we,
    input  logic [ROW_ADDR_DEPTH-1:0] req_row,
    input  logic [COL_ADDR_DEPTH-1:0] req_col,
    input  logic [MEM_ELEM_DEPTH-1:0] req_wdata,
    input  logic                      flush,
    output logic                      rd_valid,
    output logic [MEM_ELEM_DEPTH-1:0] rd_data,
    output logic                      row_open,
    output logic                      mem_activate,
    output logic                      mem_precharge,
    output logic [ROW_ADDR_DEPTH-1:0] mem_row_addr,
    output logic [ROW_W-1:0]          mem_row_in,
    input  logic [ROW_W-1:0]          mem_row_out
);

    localparam int T_MAX = (T_RCD > T_RP) ? T_RCD : T_RP;
    localparam int CNT_W = $clog2(T_MAX + 1);
    localparam logic [CNT_W-1:0] RCD_LAST = CNT_W'(T_RCD);
    localparam logic [CNT_W-1:0] RP_LAST  = CNT_W'(T_RP);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ACT  = 3'd1,
        S_LOAD = 3'd2,
        S_OPEN = 3'd3,
        S_PRE  = 3'd4
    } state_t;

    state_t                      state, state_nxt;
    logic [CNT_W-1:0]            cnt, cnt_nxt;
    logic [ROW_ADDR_DEPTH-1:0]   open_row;
    logic                        latch_row;
    logic [ROW_W-1:0]            row_buf;
    logic                        hit;
    logic                        accept;

    assign hit    = (req_row == open_row);
    assign accept = req_valid && req_ready;

    // Next-state and combinational outputs. ACT and PRE spend cycle 0 on the
    // pulse and then count the idle cycles; the counter restarts on entry.
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        latch_row     = 1'b0;
        req_ready     = 1'b0;
        row_open      = 1'b0;
        mem_activate  = 1'b0;
        mem_precharge = 1'b0;
        mem_row_addr  = open_row;

        case (state)
            S_IDLE: begin
                mem_row_addr = '0;
                if (req_valid) begin
                    latch_row = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = S_ACT;
                end
            end
            S_ACT: begin
                mem_activate = (cnt == '0);
                if (cnt == RCD_LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = S_LOAD;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            S_LOAD: begin
                state_nxt = S_OPEN;
            end
            S_OPEN: begin
                row_open = 1'b1;
                if (flush) begin
                    cnt_nxt   = '0;
                    state_nxt = S_PRE;
                end else if (req_valid && hit) begin
                    req_ready = 1'b1;
`ifdef ROWBUF_AUTO_PRECHARGE_EN
                    cnt_nxt   = '0;
                    state_nxt = S_PRE;
`endif
                end else if (req_valid) begin
                    // Miss: close this row; the pending request re-launches
                    // ACT at the end of PRE because the requester holds it.
                    cnt_nxt   = '0;
                    state_nxt = S_PRE;
                end
            end
            S_PRE: begin
                mem_precharge = (cnt == '0);
                if (cnt == RP_LAST) begin
                    cnt_nxt = '0;
                    if (req_valid) begin
                        latch_row = 1'b1;
                        state_nxt = S_ACT;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: begin
                mem_row_addr = '0;
                cnt_nxt      = '0;
                state_nxt    = S_IDLE;
            end
        endcase
    end

    // State register and open-row latch
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            cnt      <= '0;
            open_row <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (latch_row) begin
                open_row <= req_row;
            end
        end
    end

    // Row buffer: filled from the core in LOAD, patched by accepted writes.
    // Cleared on reset so the write-back port reads 0 out of reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            row_buf <= '0;
        end else if (state == S_LOAD) begin
            row_buf <= mem_row_out;
        end else if (accept && req_we) begin
            row_buf[req_col*MEM_ELEM_DEPTH +: MEM_ELEM_DEPTH] <= req_wdata;
        end
    end

    // Read response, one cycle after acceptance
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= accept && !req_we;
            if (accept && !req_we) begin
                rd_data <= row_buf[req_col*MEM_ELEM_DEPTH +: MEM_ELEM_DEPTH];
            end
        end
    end

    assign mem_row_in = row_buf;

endmodule
